// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// alu_ctrl_seq : ALU function decode with iterative CLO/CLZ leading-bit count
// Revision     : 1.0
// ============================================================================
module alu_ctrl_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6,
  parameter int OP_W   = 3,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   aluOp,
  input  logic [FUNC_W-1:0] funcIn,
  input  logic [DATA_W-1:0] operand,
  output logic [FUNC_W-1:0] funcOut,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done
);

  localparam logic [FUNC_W-1:0] FN_CLO  = FUNC_W'(6'b000111);
  localparam logic [FUNC_W-1:0] FN_CLZ  = FUNC_W'(6'b111000);
  localparam logic [FUNC_W-1:0] FN_ADD  = FUNC_W'(6'b100000);
  localparam logic [FUNC_W-1:0] FN_SUB  = FUNC_W'(6'b100011);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                target_q, target_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FUNC_W-1:0]   dec_code;
  logic                dec_is_cnt;
  logic [CNT_W-1:0]    cnt_inc;

  always_comb begin
    dec_code = funcIn;
    case (aluOp)
      OP_W'(3'b001): dec_code = FN_CLO;
      OP_W'(3'b010): dec_code = FN_CLZ;
      OP_W'(3'b101): dec_code = FN_ADD;
      OP_W'(3'b110): dec_code = FN_ADD;
      OP_W'(3'b111): dec_code = FN_SUB;
      default:       dec_code = funcIn;
    endcase
  end

  // A count op may arrive either via aluOp or as an R-type funct field.
  assign dec_is_cnt = (dec_code == FN_CLO) || (dec_code == FN_CLZ);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          func_d = dec_code;
          if (dec_is_cnt) begin
            shift_d  = operand;
            cnt_d    = '0;
            target_d = (dec_code == FN_CLO);
            state_d  = S_SCAN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SCAN: begin
        if (shift_q[DATA_W-1] == target_q) begin
          cnt_d   = cnt_inc;
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          if (cnt_inc == CNT_MAX) state_d = S_DONE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SCAN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      func_q   <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      target_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign funcOut = func_q;
  assign count   = cnt_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_ctrl_seq : directed self-checking bench for alu_ctrl_seq
// Revision        : 1.0
// ============================================================================
module tb_alu_ctrl_seq;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int OP_W   = 3;
  localparam int FUNC_W = 6;

  logic              clk;
  logic              reset;
  logic              start;
  logic [OP_W-1:0]   aluOp;
  logic [FUNC_W-1:0] funcIn;
  logic [DATA_W-1:0] operand;
  logic [FUNC_W-1:0] funcOut;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;

  int n_assert;
  int n_fail;

  alu_ctrl_seq #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W),
    .OP_W  (OP_W),
    .FUNC_W(FUNC_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .aluOp  (aluOp),
    .funcIn (funcIn),
    .operand(operand),
    .funcOut(funcOut),
    .count  (count),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation, then watches until done has come and gone.
  task automatic run_count(input logic [2:0] op, input logic [5:0] fn,
                           input logic [31:0] opnd, output int bcyc,
                           output int pulses, output logic [5:0] cnt_o,
                           output logic [5:0] fn_o);
    bcyc   = 0;
    pulses = 0;
    cnt_o  = 'x;
    fn_o   = 'x;
    @(negedge clk);
    start   = 1'b1;
    aluOp   = op;
    funcIn  = fn;
    operand = opnd;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcyc++;
      if (done) begin
        pulses++;
        cnt_o = count;
        fn_o  = funcOut;
      end else if (pulses > 0 && !busy) begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b1;
    aluOp   = 3'b101;
    funcIn  = 6'b101010;
    operand = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert++;
      if ({funcOut, count, busy, done} !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_cyc%0d: funcOut=%b count=%0d busy=%b done=%b, required all zero",
                 i, funcOut, count, busy, done);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({funcOut, count, busy, done} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_release: funcOut=%b count=%0d busy=%b done=%b, required idle zeros",
               funcOut, count, busy, done);
    end
  endtask

  task automatic test_decode();
    logic [2:0] ops [5];
    logic [5:0] fns [5];
    logic [5:0] exp [5];
    ops[0] = 3'b101; fns[0] = 6'b101010; exp[0] = 6'b100000;
    ops[1] = 3'b011; fns[1] = 6'b101010; exp[1] = 6'b101010;
    ops[2] = 3'b000; fns[2] = 6'b100101; exp[2] = 6'b100101;
    ops[3] = 3'b111; fns[3] = 6'b000000; exp[3] = 6'b100011;
    ops[4] = 3'b110; fns[4] = 6'b111111; exp[4] = 6'b100000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start  = 1'b1;
      aluOp  = ops[k];
      funcIn = fns[k];
      @(negedge clk);
      start = 1'b0;
      n_assert++;
      if (done !== 1'b1 || busy !== 1'b0 || funcOut !== exp[k]) begin
        n_fail++;
        $display("FAIL decode_op%b: done=%b busy=%b funcOut=%b, required done=1 busy=0 funcOut=%b",
                 ops[k], done, busy, funcOut, exp[k]);
      end
      @(negedge clk);
      n_assert++;
      if (done !== 1'b0 || busy !== 1'b0 || funcOut !== exp[k]) begin
        n_fail++;
        $display("FAIL decode_hold_op%b: done=%b busy=%b funcOut=%b, required done=0 busy=0 funcOut=%b",
                 ops[k], done, busy, funcOut, exp[k]);
      end
    end
  endtask

  task automatic test_count();
    logic [2:0]  ops  [5];
    logic [5:0]  fns  [5];
    logic [31:0] opd  [5];
    int          ebsy [5];
    logic [5:0]  ecnt [5];
    logic [5:0]  efn  [5];
    int          bc, np;
    logic [5:0]  c, f;
    ops[0] = 3'b010; fns[0] = 6'b0;      opd[0] = 32'h00F00000; ebsy[0] = 9;  ecnt[0] = 6'd8;  efn[0] = 6'b111000;
    ops[1] = 3'b001; fns[1] = 6'b0;      opd[1] = 32'hFFFFFFFF; ebsy[1] = 32; ecnt[1] = 6'd32; efn[1] = 6'b000111;
    ops[2] = 3'b001; fns[2] = 6'b0;      opd[2] = 32'h7FFFFFFF; ebsy[2] = 1;  ecnt[2] = 6'd0;  efn[2] = 6'b000111;
    ops[3] = 3'b000; fns[3] = 6'b000111; opd[3] = 32'hF0000000; ebsy[3] = 5;  ecnt[3] = 6'd4;  efn[3] = 6'b000111;
    ops[4] = 3'b000; fns[4] = 6'b111000; opd[4] = 32'h00000000; ebsy[4] = 32; ecnt[4] = 6'd32; efn[4] = 6'b111000;
    for (int k = 0; k < 5; k++) begin
      run_count(ops[k], fns[k], opd[k], bc, np, c, f);
      n_assert++;
      if (np !== 1 || bc !== ebsy[k] || c !== ecnt[k] || f !== efn[k]) begin
        n_fail++;
        $display("FAIL count_%0d op=%h: pulses=%0d busy_cyc=%0d count=%0d funcOut=%b, required 1/%0d/%0d/%b",
                 k, opd[k], np, bc, c, f, ebsy[k], ecnt[k], efn[k]);
      end
      n_assert++;
      if (count !== ecnt[k] || funcOut !== efn[k]) begin
        n_fail++;
        $display("FAIL count_hold_%0d: count=%0d funcOut=%b, required %0d/%b",
                 k, count, funcOut, ecnt[k], efn[k]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int bc;
    bit finished;
    bc = 0;
    finished = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    aluOp   = 3'b010;
    funcIn  = 6'b0;
    operand = 32'h0000FFFF;
    for (int i = 0; i < 80 && !finished; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) begin
        bc++;
        if (bc == 3) begin
          start   = 1'b1;
          aluOp   = 3'b101;
          operand = 32'hFFFFFFFF;
        end
      end
      if (done) begin
        finished = 1'b1;
        n_assert++;
        if (bc !== 17 || count !== 6'd16 || funcOut !== 6'b111000) begin
          n_fail++;
          $display("FAIL ignore_scan: busy_cyc=%0d count=%0d funcOut=%b, required 17/16/111000",
                   bc, count, funcOut);
        end
        start = 1'b1;
        aluOp = 3'b101;
        @(negedge clk);
        start = 1'b0;
        n_assert++;
        if (done !== 1'b0 || busy !== 1'b0 || funcOut !== 6'b111000 || count !== 6'd16) begin
          n_fail++;
          $display("FAIL ignore_done: done=%b busy=%b funcOut=%b count=%0d, required 0/0/111000/16",
                   done, busy, funcOut, count);
        end
      end
    end
    n_assert++;
    if (!finished) begin
      n_fail++;
      $display("FAIL ignore_timeout: done=%b, required a done pulse within 80 cycles", done);
    end
  endtask

  task automatic test_reset_midscan();
    int bc, np;
    logic [5:0] c, f;
    bc = 0;
    np = 0;
    @(negedge clk);
    start   = 1'b1;
    aluOp   = 3'b010;
    funcIn  = 6'b0;
    operand = 32'h00000001;
    for (int i = 0; i < 10 && bc < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_assert++;
    if (bc !== 5 || busy !== 1'b0 || done !== 1'b0 || count !== 6'd0 || funcOut !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_midscan: bc=%0d busy=%b done=%b count=%0d funcOut=%b, required 5/0/0/0/000000",
               bc, busy, done, count, funcOut);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) np++;
    end
    n_assert++;
    if (np !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: activity_cycles=%0d, required 0", np);
    end
    run_count(3'b010, 6'b0, 32'h00000001, bc, np, c, f);
    n_assert++;
    if (np !== 1 || bc !== 32 || c !== 6'd31 || f !== 6'b111000) begin
      n_fail++;
      $display("FAIL reset_restart: pulses=%0d busy_cyc=%0d count=%0d funcOut=%b, required 1/32/31/111000",
               np, bc, c, f);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    aluOp    = '0;
    funcIn   = '0;
    operand  = '0;
    test_reset();
    test_decode();
    test_count();
    test_ignore_start();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
